reg_wport_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback and a multi-cycle unit (divider/multiplier result path). Multi-cycle results are buffered in a small FIFO and drained in free writeback slots. A starvation guard forces a drain slot when needed. A 32-entry busy scoreboard tells decode to stall on reads of registers with an outstanding multi-cycle result.

---
 rtl/reg_wport_arbiter_pkg.sv | 14 +
 rtl/wport_fifo.sv | 47 ++++
 rtl/reg_wport_arbiter.sv | 144 ++++++++++++++
 tb/tb_reg_wport_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wport_arbiter_pkg.sv
// Shared widths and write-port grant-source encoding for reg_wport_arbiter.
package reg_wport_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_WB    = 2'd1,
        GNT_MC    = 2'd2,
        GNT_GUARD = 2'd3
    } gnt_e;

endpackage

// File: rtl/wport_fifo.sv
// Sync FIFO for multi-cycle results; pushed entry visible at head the cycle after push.
// Backpressure: full blocks push even when popping in the same cycle; pop on empty is ignored.
module wport_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_dat;
    end

endmodule

// File: rtl/reg_wport_arbiter.sv
// Arbitrates the regfile write port between pipeline writeback and buffered multi-cycle results.
// Latency: 1 cycle grant->write; mc_ready drops when the FIFO is full, wb_hold freezes writeback on a guard slot.
module reg_wport_arbiter
    import reg_wport_arbiter_pkg::*;
#(
    parameter int AW     = REG_AW,
    parameter int DW     = REG_DW,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    output logic          wb_hold,
    input  logic          mc_issue,
    input  logic [AW-1:0] mc_issue_addr,
    input  logic          mc_valid,
    input  logic [AW-1:0] mc_waddr,
    input  logic [DW-1:0] mc_wdata,
    output logic          mc_ready,
    input  logic          rd_en1,
    input  logic          rd_en2,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          stall,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          waw_err
);
    localparam int NREG = 1 << AW;
    localparam int SW   = $clog2(STARVE + 1);

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [AW+DW-1:0] fifo_head;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    gnt_e             gnt;

    logic [SW-1:0]    starve_q, starve_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             we_q, we_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             waw_q, waw_d;

    wport_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({mc_waddr, mc_wdata}),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    assign {head_addr, head_data} = fifo_head;
    assign mc_ready  = !fifo_full;
    assign fifo_push = mc_valid && !fifo_full;

    always_comb begin
        gnt = GNT_NONE;
        if (!fifo_empty && starve_q == SW'(STARVE)) begin
            gnt = GNT_GUARD;
        end else if (wb_we && wb_waddr != '0) begin
            gnt = GNT_WB;
        end else if (!fifo_empty) begin
            gnt = GNT_MC;
        end
    end

    assign fifo_pop = (gnt == GNT_GUARD) || (gnt == GNT_MC);
    assign wb_hold  = (gnt == GNT_GUARD);
    assign stall    = (rd_en1 && busy_q[rd_addr1]) || (rd_en2 && busy_q[rd_addr2]);

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (gnt)
            GNT_WB: begin
                we_d    = 1'b1;
                waddr_d = wb_waddr;
                wdata_d = wb_wdata;
            end
            GNT_MC, GNT_GUARD: begin
                // r0 results drain out of the FIFO without touching the regfile.
                we_d    = (head_addr != '0);
                waddr_d = head_addr;
                wdata_d = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) busy_d[head_addr] = 1'b0;
        // Issue applied after the drain clear so a re-issue to the same register stays busy.
        if (mc_issue) busy_d[mc_issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign waw_d = waw_q || ((gnt == GNT_WB) && busy_q[wb_waddr]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            waw_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            waw_q    <= waw_d;
        end
    end

    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign waw_err = waw_q;

endmodule

// File: tb/tb_reg_wport_arbiter.sv
// Bench for reg_wport_arbiter: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_reg_wport_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          wb_hold;
    logic          mc_issue;
    logic [AW-1:0] mc_issue_addr;
    logic          mc_valid;
    logic [AW-1:0] mc_waddr;
    logic [DW-1:0] mc_wdata;
    logic          mc_ready;
    logic          rd_en1, rd_en2;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic          stall;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          waw_err;

    reg_wport_arbiter #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE(STARVE)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_hold(wb_hold),
        .mc_issue(mc_issue), .mc_issue_addr(mc_issue_addr),
        .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
        .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .stall(stall), .we(we), .waddr(waddr), .wdata(wdata), .waw_err(waw_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          fq[$];
    bit            busy_m[32];
    int            starve_m;
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    logic          exp_waw;
    logic          hold_m;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        foreach (busy_m[i]) busy_m[i] = 0;
        starve_m  = 0;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_waw   = 1'b0;
        hold_m    = 1'b0;
    endtask

    task automatic idle();
        wb_we = 0; wb_waddr = '0; wb_wdata = '0;
        mc_issue = 0; mc_issue_addr = '0;
        mc_valid = 0; mc_waddr = '0; mc_wdata = '0;
        rd_en1 = 0; rd_en2 = 0; rd_addr1 = '0; rd_addr2 = '0;
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        bit   ne, guard, rdy, pop, wbg;
        ent_t e;
        #1;
        ne    = fq.size() > 0;
        guard = ne && (starve_m == STARVE);
        rdy   = fq.size() < DEPTH;
        chk("wb_hold", 32'(wb_hold), 32'(guard));
        chk("mc_ready", 32'(mc_ready), 32'(rdy));
        chk("stall", 32'(stall),
            32'((rd_en1 && busy_m[rd_addr1]) || (rd_en2 && busy_m[rd_addr2])));
        wbg = !guard && wb_we && (wb_waddr != 0);
        pop = guard || (!wbg && ne);
        if (wbg) begin
            if (busy_m[wb_waddr]) exp_waw = 1'b1;
            exp_we    = 1'b1;
            exp_waddr = wb_waddr;
            exp_wdata = wb_wdata;
        end else if (pop) begin
            e = fq.pop_front();
            exp_we = (e.a != 0);
            if (e.a != 0) begin
                exp_waddr = e.a;
                exp_wdata = e.d;
            end
            busy_m[e.a] = 0;
        end else begin
            exp_we = 1'b0;
        end
        if (pop || !ne) starve_m = 0;
        else if (starve_m < STARVE) starve_m++;
        if (mc_valid && rdy) begin
            e.a = mc_waddr;
            e.d = mc_wdata;
            fq.push_back(e);
        end
        if (mc_issue && mc_issue_addr != 0) busy_m[mc_issue_addr] = 1;
        hold_m = guard;
        @(posedge clk);
        #1;
        chk("we", 32'(we), 32'(exp_we));
        if (exp_we) begin
            chk("waddr", 32'(waddr), 32'(exp_waddr));
            chk("wdata", wdata, exp_wdata);
        end
        chk("waw_err", 32'(waw_err), 32'(exp_waw));
        @(negedge clk);
    endtask

    task automatic drain_idle();
        repeat (4) begin
            idle();
            step();
        end
    endtask

    initial begin
        int first_hold;
        bit acc;

        rst = 1'b0;
        idle();
        model_reset();
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_waw", 32'(waw_err), 32'd0);
        chk("rst_mc_ready", 32'(mc_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle drain of a single r5 result
        idle(); mc_issue = 1; mc_issue_addr = 5; step();
        idle(); mc_valid = 1; mc_waddr = 5; mc_wdata = 32'h1234;
        rd_en1 = 1; rd_addr1 = 5; step();
        idle(); rd_en1 = 1; rd_addr1 = 5; step();
        chk("drain_we", 32'(we), 32'd1);
        chk("drain_waddr", 32'(waddr), 32'd5);
        chk("drain_wdata", wdata, 32'h1234);
        idle(); rd_en1 = 1; rd_addr1 = 5; step();

        // Pipeline beats a queued result
        idle(); mc_valid = 1; mc_waddr = 7; mc_wdata = 32'hA; step();
        idle(); wb_we = 1; wb_waddr = 3; wb_wdata = 32'hB; step();
        chk("prio_first", 32'(waddr), 32'd3);
        idle(); step();
        chk("prio_second", 32'(waddr), 32'd7);
        drain_idle();

        // Starvation guard
        idle(); mc_valid = 1; mc_waddr = 9; mc_wdata = 32'hC; step();
        first_hold = -1;
        mc_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (!hold_m) begin
                wb_we = 1; wb_waddr = 5'(10 + i); wb_wdata = 32'(100 + i);
            end
            #1;
            if (wb_hold && first_hold < 0) first_hold = i;
            step();
        end
        chk("starve_first_hold", 32'(first_hold), 32'd4);
        drain_idle();

        // Full FIFO
        idle(); wb_we = 1; wb_waddr = 1; wb_wdata = 32'h11;
        mc_valid = 1; mc_waddr = 11; mc_wdata = 32'hD1; step();
        wb_waddr = 2; wb_wdata = 32'h12; mc_waddr = 12; mc_wdata = 32'hD2; step();
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) begin
            if (!hold_m) begin
                wb_we = 1; wb_waddr = 5'(20 + i); wb_wdata = 32'(200 + i);
            end
            mc_valid = 1; mc_waddr = 13; mc_wdata = 32'hD3;
            #1;
            if (i == 0) chk("full_rdy0", 32'(mc_ready), 32'd0);
            acc = fq.size() < DEPTH;
            step();
        end
        drain_idle();

        // Hazards: r0 issue, and WAW on busy r4
        idle(); mc_issue = 1; mc_issue_addr = 0; rd_en1 = 1; rd_addr1 = 0; step();
        idle(); rd_en1 = 1; rd_addr1 = 0; step();
        idle(); mc_issue = 1; mc_issue_addr = 4; step();
        idle(); wb_we = 1; wb_waddr = 4; wb_wdata = 32'h44; step();
        chk("waw_set", 32'(waw_err), 32'd1);
        idle(); step();
        chk("waw_sticky", 32'(waw_err), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (!hold_m) begin
                wb_we    = 1'($urandom_range(0, 1));
                wb_waddr = 5'($urandom_range(0, 7));
                wb_wdata = $urandom;
            end
            mc_valid      = ($urandom_range(0, 2) == 0);
            mc_waddr      = 5'($urandom_range(0, 7));
            mc_wdata      = $urandom;
            mc_issue      = ($urandom_range(0, 3) == 0);
            mc_issue_addr = 5'($urandom_range(0, 7));
            rd_en1        = 1'($urandom_range(0, 1));
            rd_en2        = 1'($urandom_range(0, 1));
            rd_addr1      = 5'($urandom_range(0, 7));
            rd_addr2      = 5'($urandom_range(0, 7));
            step();
        end
        drain_idle();

        // Async reset with two results queued and r6 busy
        idle(); mc_issue = 1; mc_issue_addr = 6;
        wb_we = 1; wb_waddr = 2; wb_wdata = 32'h22;
        mc_valid = 1; mc_waddr = 6; mc_wdata = 32'h66; step();
        mc_issue = 0; wb_waddr = 3; wb_wdata = 32'h33;
        mc_waddr = 6; mc_wdata = 32'h67; step();
        idle(); rd_en1 = 1; rd_addr1 = 6;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_mc_ready", 32'(mc_ready), 32'd1);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_waw", 32'(waw_err), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            idle(); rd_en1 = 1; rd_addr1 = 6;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
